demux10_seq: RTL and testbench
==============================

Name: demux10_seq

Overview:
- 1-to-10 word distributor; the inverse of the 10-input 16-bit mux10 selector.
- Accepts a 16-bit input word stream over a valid/ready handshake.
- Steers each accepted word into one of ten registered output lanes, either at an explicit lane select or at an auto-incrementing pointer.
- Flags a complete 10-lane frame and holds it until the consumer acknowledges, so downstream mux10 instances see stable lane data.

Parameters:
- WIDTH, 16, data width of the input word and of each output lane.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = addressed (lane taken from s), 1 = auto-sequence (lane taken from internal pointer).
- d_in  input  WIDTH  data word.
- s  input  4  lane select, addressed mode only; valid range 0..9.
- in_valid  input  1  d_in (and s) valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- frame_ack  input  1  consumer releases a held frame.
- q0..q9  output  WIDTH each  registered lane outputs.
- lane_valid  output  10  bit i set once lane i has been written in the current frame.
- ptr  output  4  auto-sequence write pointer, 0..9.
- frame_done  output  1  one-cycle pulse when the frame completes.
- err_sel  output  1  one-cycle pulse when an addressed write has s > 9.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-frame):
  - q0..q9 = 0, lane_valid = 0, ptr = 0, frame_done = 0, err_sel = 0.
  - State = FILL, latched mode = 0.
  - in_ready = 1 from the first cycle after reset.
- States:
  - FILL: in_ready = 1.
  - HOLD: in_ready = 0, all writes refused, q and lane_valid frozen.
- Accept: an accept happens when in_valid & in_ready are both high at a rising edge. The written lane shows the new q value on the following cycle (1-cycle latency).
- Mode latch: the mode input is copied into an internal register only on edges where lane_valid == 0. Changing mode mid-frame has no effect until the next frame.
- Addressed mode, accept with s in 0..9:
  - q[s] <= d_in and lane_valid[s] <= 1.
  - Rewriting an already-valid lane overwrites the data; lane_valid is unchanged.
  - ptr is not used.
- Addressed mode, accept with s in 10..15:
  - The word is discarded; no q or lane_valid change.
  - err_sel = 1 for the next cycle only.
- Auto mode, accept:
  - q[ptr] <= d_in, lane_valid[ptr] <= 1, ptr <= ptr + 1.
  - ptr wraps from 9 to 0 on the completing write.
  - s is ignored; err_sel never asserts.
- Frame complete: on the edge where an accept makes lane_valid all ones, the block enters HOLD and frame_done = 1 for exactly the next cycle.
- HOLD exit: frame_ack = 1 at an edge while in HOLD:
  - Next state FILL, lane_valid <= 0, ptr <= 0.
  - q values are retained, not cleared.
- frame_ack while in FILL: ignored.
- in_valid while in HOLD: ignored; the source must hold its word until in_ready returns.
- Priority at an edge: rst > frame_ack (in HOLD) > accept.
- No combinational path from inputs to outputs except none at all: every output is a register or a decode of state.

Test Plan:
- Auto fill: mode=1; send 000A,000B,000C,000D,000E,000F,0001,0002,0003,0004 on consecutive cycles → q0..q9 equal those values in order; ptr steps 0..9 then 0; frame_done high one cycle after the 10th accept; in_ready low afterwards.
- Hold/ack: during HOLD drive in_valid=1 with d_in=FFFF for 3 cycles → q unchanged; then pulse frame_ack → lane_valid=0, ptr=0, q0=000A retained, in_ready=1.
- Addressed out-of-order: mode=0; write s=9..0 with d_in=0x0009..0x0000 → q[i]=i; frame_done after the s=0 write; overwriting s=3 with 00AA before completion → q3=00AA, no early frame_done.
- Bad select: mode=0; s=4'hC, d_in=1234 → err_sel pulses one cycle; lane_valid and all q unchanged; in_ready stays 1.
- Mid-frame mode change and reset: mode=1, 4 words written, switch mode to 0 → the next word still goes to q4 via ptr. Assert rst → all q=0, lane_valid=0, ptr=0, frame_done=0.

Source files
------------

// File: rtl/demux10_seq.sv
// rtl/demux10_seq.sv - 1-to-10 word distributor with frame hold and acknowledge
module demux10_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic [3:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [9:0]       lane_valid,
  output logic [3:0]       ptr,
  output logic             frame_done,
  output logic             err_sel
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] q_q [10];
  logic [WIDTH-1:0] q_d [10];
  logic [9:0]       lane_valid_q, lane_valid_d;
  logic [3:0]       ptr_q, ptr_d;
  logic             frame_done_q, frame_done_d;
  logic             err_sel_q, err_sel_d;

  logic             frame_empty;
  logic             eff_mode;
  logic             accept;
  logic [3:0]       wr_lane;
  logic             wr_ok;

  // Next-state logic: mode latch, lane writes, pointer advance, frame completion and release
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lane_valid_d = lane_valid_q;
    ptr_d        = ptr_q;
    frame_done_d = 1'b0;
    err_sel_d    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q_d[i] = q_q[i];
    end

    // The mode register only follows the input while no lane of the frame is written,
    // and a frame's first word already uses the mode presented with it.
    frame_empty = (lane_valid_q == 10'd0);
    eff_mode    = frame_empty ? mode : mode_q;
    if (frame_empty) begin
      mode_d = mode;
    end

    accept  = in_valid && (state_q == FILL);
    wr_lane = eff_mode ? ptr_q : s;
    wr_ok   = eff_mode || (s <= 4'd9);

    if (state_q == HOLD) begin
      if (frame_ack) begin
        state_d      = FILL;
        lane_valid_d = 10'd0;
        ptr_d        = 4'd0;
      end
    end else if (accept) begin
      if (wr_ok) begin
        for (int i = 0; i < 10; i++) begin
          if (wr_lane == 4'(i)) begin
            q_d[i]          = d_in;
            lane_valid_d[i] = 1'b1;
          end
        end
        if (eff_mode) begin
          ptr_d = (ptr_q == 4'd9) ? 4'd0 : ptr_q + 4'd1;
        end
        if (lane_valid_d == 10'h3FF) begin
          state_d      = HOLD;
          frame_done_d = 1'b1;
        end
      end else begin
        err_sel_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      mode_q       <= 1'b0;
      lane_valid_q <= 10'd0;
      ptr_q        <= 4'd0;
      frame_done_q <= 1'b0;
      err_sel_q    <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lane_valid_q <= lane_valid_d;
      ptr_q        <= ptr_d;
      frame_done_q <= frame_done_d;
      err_sel_q    <= err_sel_d;
      for (int i = 0; i < 10; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

  assign in_ready   = (state_q == FILL);
  assign lane_valid = lane_valid_q;
  assign ptr        = ptr_q;
  assign frame_done = frame_done_q;
  assign err_sel    = err_sel_q;
  assign q0         = q_q[0];
  assign q1         = q_q[1];
  assign q2         = q_q[2];
  assign q3         = q_q[3];
  assign q4         = q_q[4];
  assign q5         = q_q[5];
  assign q6         = q_q[6];
  assign q7         = q_q[7];
  assign q8         = q_q[8];
  assign q9         = q_q[9];

endmodule

// File: tb/tb_demux10_seq.sv
// tb/tb_demux10_seq.sv - table-driven self-checking bench for demux10_seq
module tb_demux10_seq;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [15:0] d_in;
  logic [3:0]  s;
  logic        in_valid;
  logic        in_ready;
  logic        frame_ack;
  logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9;
  logic [9:0]  lane_valid;
  logic [3:0]  ptr;
  logic        frame_done;
  logic        err_sel;

  int n_checks = 0;
  int n_fail   = 0;

  demux10_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .d_in       (d_in),
    .s          (s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frame_ack  (frame_ack),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .q4         (q4),
    .q5         (q5),
    .q6         (q6),
    .q7         (q7),
    .q8         (q8),
    .q9         (q9),
    .lane_valid (lane_valid),
    .ptr        (ptr),
    .frame_done (frame_done),
    .err_sel    (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic        vld;
    logic [3:0]  s;
    logic [15:0] d;
    logic        ack;
    logic        rdy;
    logic [9:0]  lv;
    logic [3:0]  ptr;
    logic        fd;
    logic        err;
    int          lane;
    logic [15:0] q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic m, input logic v, input logic [3:0] sel,
                              input logic [15:0] d, input logic a, input logic rdy,
                              input logic [9:0] lv, input logic [3:0] p, input logic fd,
                              input logic err, input int lane, input logic [15:0] q);
    vec_t t;
    t.rst = r; t.mode = m; t.vld = v; t.s = sel; t.d = d; t.ack = a;
    t.rdy = rdy; t.lv = lv; t.ptr = p; t.fd = fd; t.err = err; t.lane = lane; t.q = q;
    return t;
  endfunction

  function automatic logic [15:0] get_q(input int lane);
    case (lane)
      0: return q0;
      1: return q1;
      2: return q2;
      3: return q3;
      4: return q4;
      5: return q5;
      6: return q6;
      7: return q7;
      8: return q8;
      default: return q9;
    endcase
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    mode      = v.mode;
    in_valid  = v.vld;
    s         = v.s;
    d_in      = v.d;
    frame_ack = v.ack;
  endtask

  logic [15:0] av [10];
  logic [9:0]  lvt;

  initial begin
    av = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
           16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    // reset
    vecs.push_back(mk(1, 0, 0, 4'h0, 16'h0, 0, 1, 10'h000, 4'd0, 0, 0, 0, 16'h0));
    // auto fill, s driven out of range to show it is ignored
    for (int i = 0; i < 10; i++) begin
      lvt = 10'((1 << (i + 1)) - 1);
      vecs.push_back(mk(0, 1, 1, 4'hF, av[i], 0, (i < 9), lvt, 4'((i + 1) % 10),
                        (i == 9), 0, i, av[i]));
    end
    // hold: writes refused
    vecs.push_back(mk(0, 1, 1, 4'h0, 16'hFFFF, 0, 0, 10'h3FF, 4'd0, 0, 0, 0, 16'h000A));
    vecs.push_back(mk(0, 1, 1, 4'h0, 16'hFFFF, 0, 0, 10'h3FF, 4'd0, 0, 0, 5, 16'h000F));
    vecs.push_back(mk(0, 1, 1, 4'h0, 16'hFFFF, 0, 0, 10'h3FF, 4'd0, 0, 0, 9, 16'h0004));
    // ack beats the pending word
    vecs.push_back(mk(0, 1, 1, 4'h0, 16'hFFFF, 1, 1, 10'h000, 4'd0, 0, 0, 0, 16'h000A));
    // ack in FILL ignored
    vecs.push_back(mk(0, 0, 0, 4'h0, 16'h0, 1, 1, 10'h000, 4'd0, 0, 0, 9, 16'h0004));
    // addressed, descending, with an overwrite of lane 3
    lvt = 10'h3FF;
    for (int k = 9; k >= 0; k--) begin
      lvt = 10'h3FF << k;
      vecs.push_back(mk(0, 0, 1, 4'(k), 16'(k), 0, (k != 0), lvt, 4'd0, (k == 0), 0, k, 16'(k)));
      if (k == 3) begin
        vecs.push_back(mk(0, 0, 1, 4'd3, 16'h00AA, 0, 1, lvt, 4'd0, 0, 0, 3, 16'h00AA));
      end
    end
    vecs.push_back(mk(0, 0, 0, 4'h0, 16'h0, 0, 0, 10'h3FF, 4'd0, 0, 0, 3, 16'h00AA));
    vecs.push_back(mk(0, 0, 0, 4'h0, 16'h0, 1, 1, 10'h000, 4'd0, 0, 0, 9, 16'h0009));
    // bad select
    vecs.push_back(mk(0, 0, 1, 4'hC, 16'h1234, 0, 1, 10'h000, 4'd0, 0, 1, 4, 16'h0004));
    vecs.push_back(mk(0, 0, 0, 4'hC, 16'h1234, 0, 1, 10'h000, 4'd0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 4'hA, 16'h5555, 0, 1, 10'h000, 4'd0, 0, 1, 9, 16'h0009));
    // auto frame start, then mode switched mid-frame
    for (int i = 0; i < 4; i++) begin
      lvt = 10'((1 << (i + 1)) - 1);
      vecs.push_back(mk(0, 1, 1, 4'h0, 16'h0100 + 16'(i), 0, 1, lvt, 4'(i + 1), 0, 0, i,
                        16'h0100 + 16'(i)));
    end
    vecs.push_back(mk(0, 0, 1, 4'hF, 16'h0104, 0, 1, 10'h01F, 4'd5, 0, 0, 4, 16'h0104));
    vecs.push_back(mk(0, 0, 1, 4'h1, 16'h0105, 0, 1, 10'h03F, 4'd6, 0, 0, 5, 16'h0105));
    vecs.push_back(mk(0, 0, 0, 4'h1, 16'h0, 0, 1, 10'h03F, 4'd6, 0, 0, 1, 16'h0101));

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; s = 4'h0; d_in = 16'h0; frame_ack = 1'b0;
    @(negedge clk);

    foreach (vecs[idx]) begin
      drive(vecs[idx]);
      @(posedge clk);
      @(negedge clk);
      chk("in_ready",   idx, 32'(in_ready),        32'(vecs[idx].rdy));
      chk("lane_valid", idx, 32'(lane_valid),      32'(vecs[idx].lv));
      chk("ptr",        idx, 32'(ptr),             32'(vecs[idx].ptr));
      chk("frame_done", idx, 32'(frame_done),      32'(vecs[idx].fd));
      chk("err_sel",    idx, 32'(err_sel),         32'(vecs[idx].err));
      chk("q_lane",     idx, 32'(get_q(vecs[idx].lane)), 32'(vecs[idx].q));
    end

    // mid-frame reset with a word offered: everything clears
    rst = 1'b1; in_valid = 1'b1; mode = 1'b1; d_in = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_q", 100 + i, 32'(get_q(i)), 32'h0);
    end
    chk("rst_lane_valid", 200, 32'(lane_valid), 32'h0);
    chk("rst_ptr",        201, 32'(ptr),        32'h0);
    chk("rst_frame_done", 202, 32'(frame_done), 32'h0);
    chk("rst_err_sel",    203, 32'(err_sel),    32'h0);
    chk("rst_in_ready",   204, 32'(in_ready),   32'h1);

    // reset while holding a full frame returns to FILL
    mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_in = 16'h0200 + 16'(i);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_ready",  300, 32'(in_ready), 32'h0);
    chk("full_q7",     301, 32'(q7),       32'h0207);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("hold_rst_ready", 302, 32'(in_ready),   32'h1);
    chk("hold_rst_lv",    303, 32'(lane_valid), 32'h0);
    chk("hold_rst_q7",    304, 32'(q7),         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
